mux_scan_capture: RTL and testbench

//   Drives the select lines of the 4:1 bit-mux stage and consumes its output bit.
//   On a start request it steps the select through channels 0..N_INPUTS-1. It waits

---
 rtl/mux_scan_capture.sv | 79 +++++++
 tb/tb_mux_scan_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_capture.sv
// mux_scan_capture: steps the mux select through every channel, samples each after a settle
// window and publishes the assembled word atomically with a done pulse.
module mux_scan_capture #(
    parameter int N_INPUTS      = 4,
    parameter int SEL_W         = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                cont_mode,
    input  logic                mux_bit,
    output logic [SEL_W-1:0]    sel,
    output logic                busy,
    output logic                done,
    output logic [N_INPUTS-1:0] data_out,
    output logic [7:0]          scan_count
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(N_INPUTS - 1);
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
    state_t              state;
    logic [3:0]          cnt;
    logic [N_INPUTS-2:0] staging;
    // The last channel bypasses staging and lands straight in data_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_out   <= '0;
            scan_count <= '0;
            staging    <= '0;
            cnt        <= '0;
        end else if (abort && state != IDLE) begin
            state   <= IDLE;
            sel     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            staging <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start && !abort) begin
                    state <= SETTLE;
                    sel   <= '0;
                    cnt   <= SETTLE_LOAD;
                    busy  <= 1'b1;
                end
                SETTLE: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= SAMPLE;
                end
                SAMPLE: if (sel != LAST_SEL) begin
                    staging[sel] <= mux_bit;
                    sel          <= sel + SEL_W'(1);
                    cnt          <= SETTLE_LOAD;
                    state        <= SETTLE;
                end else begin
                    data_out   <= {mux_bit, staging};
                    scan_count <= scan_count + 8'd1;
                    staging    <= '0;
                    done       <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    sel   <= '0;
                    cnt   <= SETTLE_LOAD;
                    busy  <= cont_mode;
                    state <= cont_mode ? SETTLE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_scan_capture.sv
// tb_mux_scan_capture: directed checks of the scan FSM with SETTLE_CYCLES=1 and =3 instances
// driven from the same stimulus, each fed by its own mux model.
module tb_mux_scan_capture;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, cont_mode = 1'b0, glitch = 1'b0;
    logic [3:0] pat = 4'b0000;
    logic [1:0] sel, sel3;
    logic       busy, busy3, done, done3, mux_bit, mux_bit3;
    logic [3:0] data_out, data3;
    logic [7:0] scan_count, count3;
    int         vectors = 0, miscompares = 0;

    // glitch corrupts the slow instance's mux bit outside its sample cycle
    assign mux_bit  = pat[sel];
    assign mux_bit3 = pat[sel3] ^ glitch;

    always #5 clk = ~clk;

    mux_scan_capture #(.N_INPUTS(4), .SEL_W(2), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont_mode(cont_mode),
        .mux_bit(mux_bit), .sel(sel), .busy(busy), .done(done), .data_out(data_out),
        .scan_count(scan_count));

    mux_scan_capture #(.N_INPUTS(4), .SEL_W(2), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont_mode(cont_mode),
        .mux_bit(mux_bit3), .sel(sel3), .busy(busy3), .done(done3), .data_out(data3),
        .scan_count(count3));

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cont_mode = 1'b0; glitch = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        int n = 0;
        @(negedge clk);
        vectors++;
        if ({sel, busy, done, data_out, scan_count} !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_init: sel=%0d busy=%b done=%b data_out=%b scan_count=%0d, want all 0",
                     sel, busy, done, data_out, scan_count);
        end
        rst_n = 1'b1; pat = 4'b1111;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (sel !== 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("FAIL reset_wait_sel2: sel=%0d after %0d cycles, want 2", sel, n);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({sel, busy, done, data_out, scan_count} !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid: sel=%0d busy=%b done=%b data_out=%b scan_count=%0d, want all 0",
                     sel, busy, done, data_out, scan_count);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || sel !== 2'd0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b sel=%0d done=%b, want 0 0 0", busy, sel, done);
        end
    endtask

    task automatic test_single_scan;
        logic [1:0] exp_sel;
        do_reset();
        pat = 4'b1010;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp_sel = c <= 8 ? 2'((c - 1) / 2) : (c == 9 ? 2'd3 : 2'd0);
            vectors++;
            if (sel !== exp_sel) begin
                miscompares++;
                $display("FAIL single_sel c=%0d: got %0d want %0d", c, sel, exp_sel);
            end
            vectors++;
            if (done !== (c == 9)) begin
                miscompares++;
                $display("FAIL single_done c=%0d: got %b want %b", c, done, c == 9);
            end
            vectors++;
            if (busy !== (c <= 9)) begin
                miscompares++;
                $display("FAIL single_busy c=%0d: got %b want %b", c, busy, c <= 9);
            end
            vectors++;
            if (data_out !== (c >= 9 ? 4'b1010 : 4'b0000)) begin
                miscompares++;
                $display("FAIL single_data c=%0d: got %b want %b", c, data_out, c >= 9 ? 4'b1010 : 4'b0000);
            end
        end
        vectors++;
        if (scan_count !== 8'd1) begin
            miscompares++;
            $display("FAIL single_count: got %0d want 1", scan_count);
        end
    endtask

    task automatic test_start_busy;
        int dones = 0, done_c = 0;
        do_reset();
        pat = 4'b1010;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                done_c = c;
            end
            start = (c == 3);
        end
        vectors++;
        if (dones != 1 || done_c != 9) begin
            miscompares++;
            $display("FAIL busy_start_done: %0d pulses last at c=%0d, want 1 at c=9", dones, done_c);
        end
        vectors++;
        if (scan_count !== 8'd1 || data_out !== 4'b1010) begin
            miscompares++;
            $display("FAIL busy_start_result: count=%0d data=%b, want 1 1010", scan_count, data_out);
        end
    endtask

    task automatic test_abort;
        int dones = 0;
        pat = 4'b0101;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        vectors++;
        if (sel !== 2'd2 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pre: sel=%0d busy=%b, want 2 1", sel, busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (sel !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: sel=%0d busy=%b done=%b, want 0 0 0", sel, busy, done);
        end
        vectors++;
        if (data_out !== 4'b1010 || scan_count !== 8'd1) begin
            miscompares++;
            $display("FAIL abort_hold: data=%b count=%0d, want 1010 1", data_out, scan_count);
        end
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done === 1'b1 || busy !== 1'b0) dones++;
            @(negedge clk);
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL abort_quiet: %0d active cycles after abort/start in IDLE, want 0", dones);
        end
        @(negedge clk) start = 1'b1;
        repeat (9) begin
            @(negedge clk);
            start = 1'b0;
        end
        vectors++;
        if (done !== 1'b1 || data_out !== 4'b0101 || scan_count !== 8'd2) begin
            miscompares++;
            $display("FAIL abort_rescan: done=%b data=%b count=%0d, want 1 0101 2", done, data_out, scan_count);
        end
    endtask

    task automatic test_continuous;
        logic exp_done;
        do_reset();
        pat = 4'b0110; cont_mode = 1'b1;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 9 * 257 + 1; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp_done = (c % 9 == 0) && (c <= 9 * 257);
            vectors++;
            if (done !== exp_done) begin
                miscompares++;
                $display("FAIL cont_done c=%0d: got %b want %b", c, done, exp_done);
            end
            vectors++;
            if (busy !== (c <= 9 * 257)) begin
                miscompares++;
                $display("FAIL cont_busy c=%0d: got %b want %b", c, busy, c <= 9 * 257);
            end
            if (exp_done) begin
                vectors++;
                if (scan_count !== 8'(c / 9) || data_out !== 4'b0110) begin
                    miscompares++;
                    $display("FAIL cont_result c=%0d: count=%0d data=%b, want %0d 0110",
                             c, scan_count, data_out, 8'(c / 9));
                end
            end
            if (c == 9 * 256 + 4) cont_mode = 1'b0;
        end
        vectors++;
        if (sel !== 2'd0 || scan_count !== 8'd1) begin
            miscompares++;
            $display("FAIL cont_stop: sel=%0d count=%0d, want 0 1", sel, scan_count);
        end
    endtask

    task automatic test_settle3;
        logic [1:0] exp_sel;
        do_reset();
        pat = 4'b1001;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp_sel = c <= 16 ? 2'((c - 1) / 4) : (c == 17 ? 2'd3 : 2'd0);
            vectors++;
            if (sel3 !== exp_sel) begin
                miscompares++;
                $display("FAIL s3_sel c=%0d: got %0d want %0d", c, sel3, exp_sel);
            end
            vectors++;
            if (done3 !== (c == 17) || busy3 !== (c <= 17)) begin
                miscompares++;
                $display("FAIL s3_ctrl c=%0d: done=%b busy=%b, want %b %b", c, done3, busy3, c == 17, c <= 17);
            end
            if (c == 17) begin
                vectors++;
                if (data3 !== 4'b1001 || count3 !== 8'd1) begin
                    miscompares++;
                    $display("FAIL s3_result: data=%b count=%0d, want 1001 1", data3, count3);
                end
            end
            glitch = (c <= 16) && (c % 4 != 0);
        end
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_start_busy();
        test_abort();
        test_continuous();
        test_settle3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
